// File: rtl/bus_sync_stable_n.sv
// Multi-bit CDC bus synchroniser: flop chain, run-length stability filter, update strobe and sticky timeout.
// Optional macro BUS_SYNC_STABLE_GLITCH_CNT_EN adds a saturating count of discarded pending values.
module bus_sync_stable_n #(
    parameter int                BUS_BW      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                STABLE_CNT  = 3,
    parameter int                TMO_CYC     = 256,
    parameter logic [BUS_BW-1:0] RST_VAL     = {BUS_BW{1'b0}}
) (
    input  logic              dest_clk,
    input  logic              dest_rst,
    input  logic [BUS_BW-1:0] Bus_in,
    input  logic              tmo_clr,
    output logic [BUS_BW-1:0] Bus_sync,
    output logic              Bus_upd,
    output logic              Bus_stable,
    output logic              Bus_tmo
`ifdef BUS_SYNC_STABLE_GLITCH_CNT_EN
    ,
    output logic [15:0]       glitch_cnt
`endif
);

    localparam int RUN_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT - 1);
    localparam logic [RUN_W-1:0] RUN_THR = RUN_W'(STABLE_CNT - 2);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("bus_sync_stable_n: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CNT < 2) begin : g_bad_stable
        $error("bus_sync_stable_n: STABLE_CNT must be >= 2");
    end
    if ((TMO_CYC < 0) || (TMO_CYC > 65535)) begin : g_bad_tmo
        $error("bus_sync_stable_n: TMO_CYC out of range");
    end

    logic [BUS_BW-1:0] sync_r [SYNC_STAGES];
    logic [BUS_BW-1:0] prev_r;
    logic [RUN_W-1:0]  run_r;
    logic [BUS_BW-1:0] samp_s;
    logic              eq_s;
    logic              stable_s;
    logic              upd_nxt_s;
    logic [RUN_W-1:0]  run_nxt_s;

    assign samp_s    = sync_r[SYNC_STAGES-1];
    assign eq_s      = (samp_s == prev_r);
    assign stable_s  = eq_s && (run_r >= RUN_THR);
    assign upd_nxt_s = stable_s && (samp_s != Bus_sync);

    // Synchroniser flop chain
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= RST_VAL;
        end else begin
            sync_r[0] <= Bus_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
        end
    end

    // Saturating run length of consecutive equal samples
    always_comb begin
        run_nxt_s = {RUN_W{1'b0}};
        if (eq_s) begin
            if (run_r == RUN_MAX) run_nxt_s = RUN_MAX;
            else                  run_nxt_s = run_r + RUN_W'(1);
        end else begin
            run_nxt_s = {RUN_W{1'b0}};
        end
    end

    // Filter state and registered outputs
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            prev_r     <= RST_VAL;
            run_r      <= {RUN_W{1'b0}};
            Bus_sync   <= RST_VAL;
            Bus_upd    <= 1'b0;
            Bus_stable <= 1'b0;
        end else begin
            prev_r     <= samp_s;
            run_r      <= run_nxt_s;
            Bus_upd    <= upd_nxt_s;
            Bus_stable <= stable_s;
            if (stable_s) Bus_sync <= samp_s;
        end
    end

    if (TMO_CYC > 0) begin : g_tmo
        logic [15:0] tc_r;
        logic [16:0] tc_inc_s;

        assign tc_inc_s = {1'b0, tc_r} + 17'd1;

        // Sticky timeout; clear beats set in the same cycle
        always_ff @(posedge dest_clk or posedge dest_rst) begin
            if (dest_rst) begin
                tc_r    <= 16'd0;
                Bus_tmo <= 1'b0;
            end else if (tmo_clr) begin
                tc_r    <= 16'd0;
                Bus_tmo <= 1'b0;
            end else if (stable_s) begin
                tc_r    <= 16'd0;
            end else begin
                tc_r <= tc_inc_s[16] ? 16'hFFFF : tc_inc_s[15:0];
                if (tc_inc_s == 17'(TMO_CYC)) Bus_tmo <= 1'b1;
            end
        end
    end else begin : g_no_tmo
        assign Bus_tmo = 1'b0;
    end

`ifdef BUS_SYNC_STABLE_GLITCH_CNT_EN
    logic glitch_s;
    // A pending (unaccepted) value was replaced before it could be accepted
    assign glitch_s = (samp_s != prev_r) && (prev_r != Bus_sync);

    // Saturating glitch counter, cleared with the timeout
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            glitch_cnt <= 16'd0;
        end else if (tmo_clr) begin
            glitch_cnt <= 16'd0;
        end else if (glitch_s && (glitch_cnt != 16'hFFFF)) begin
            glitch_cnt <= glitch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_sync_stable_n.sv
// Bench for bus_sync_stable_n: two configurations against a window-based reference model.
module tb_bus_sync_stable_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, clr_a, clr_b;
    logic [7:0]  in_a, sync_a;
    logic [15:0] in_b, sync_b;
    logic        upd_a, stb_a, tmo_a, upd_b, stb_b, tmo_b;
`ifdef BUS_SYNC_STABLE_GLITCH_CNT_EN
    logic [15:0] gc_a, gc_b;
`endif

    bus_sync_stable_n #(.BUS_BW(8), .SYNC_STAGES(2), .STABLE_CNT(3), .TMO_CYC(16), .RST_VAL(8'h5A)) dut_a (
        .dest_clk(clk), .dest_rst(rst_a), .Bus_in(in_a), .tmo_clr(clr_a),
        .Bus_sync(sync_a), .Bus_upd(upd_a), .Bus_stable(stb_a), .Bus_tmo(tmo_a)
`ifdef BUS_SYNC_STABLE_GLITCH_CNT_EN
        , .glitch_cnt(gc_a)
`endif
    );

    bus_sync_stable_n #(.BUS_BW(16), .SYNC_STAGES(3), .STABLE_CNT(4), .TMO_CYC(20), .RST_VAL(16'h1234)) dut_b (
        .dest_clk(clk), .dest_rst(rst_b), .Bus_in(in_b), .tmo_clr(clr_b),
        .Bus_sync(sync_b), .Bus_upd(upd_b), .Bus_stable(stb_b), .Bus_tmo(tmo_b)
`ifdef BUS_SYNC_STABLE_GLITCH_CNT_EN
        , .glitch_cnt(gc_b)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: samp(k) is the input captured S edges earlier; acceptance when the last
    // SC sample values (the reset value seeds the "previous" slot) are all identical.
    int          cfg_s   [2] = '{2, 3};
    int          cfg_sc  [2] = '{3, 4};
    int          cfg_tmo [2] = '{16, 20};
    logic [15:0] cfg_rst [2] = '{16'h005A, 16'h1234};

    logic [15:0] cap [2][8192];
    logic [15:0] vh  [2][8192];
    int          mn  [2];
    logic [15:0] m_sync [2];
    logic        m_upd [2], m_stb [2], m_tmo [2];
    int          m_nst [2], m_gc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] samp_of(input int d, input int k);
        return (k >= cfg_s[d]) ? cap[d][(k - cfg_s[d] + 1) & 8191] : cfg_rst[d];
    endfunction

    task automatic model_reset(input int d);
        mn[d] = 0;
        vh[d][0] = cfg_rst[d];
        vh[d][1] = cfg_rst[d];
        m_sync[d] = cfg_rst[d];
        m_upd[d] = 1'b0; m_stb[d] = 1'b0; m_tmo[d] = 1'b0;
        m_nst[d] = 0; m_gc[d] = 0;
    endtask

    task automatic model_edge(input int d, input logic [15:0] bin, input logic clr);
        int k;
        logic [15:0] cur, prv;
        logic st;
        k = mn[d];
        cur = vh[d][(k + 1) & 8191];
        prv = vh[d][k & 8191];
        st = 1'b0;
        if (k + 2 >= cfg_sc[d]) begin
            st = 1'b1;
            for (int j = 0; j < cfg_sc[d]; j++)
                if (vh[d][(k + 1 - j) & 8191] != cur) st = 1'b0;
        end
        if (clr) m_gc[d] = 0;
        else if ((cur != prv) && (prv != m_sync[d]) && (m_gc[d] < 65535)) m_gc[d]++;
        m_upd[d] = st && (cur != m_sync[d]);
        if (st) m_sync[d] = cur;
        m_stb[d] = st;
        if (cfg_tmo[d] > 0) begin
            if (clr) begin
                m_nst[d] = 0; m_tmo[d] = 1'b0;
            end else if (st) begin
                m_nst[d] = 0;
            end else begin
                if (m_nst[d] < 65535) m_nst[d]++;
                if (m_nst[d] == cfg_tmo[d]) m_tmo[d] = 1'b1;
            end
        end
        mn[d] = k + 1;
        cap[d][(k + 1) & 8191] = bin;
        vh[d][(k + 2) & 8191] = samp_of(d, k + 1);
    endtask

    task automatic check_all();
        chk("a_sync", {24'd0, sync_a}, {16'd0, m_sync[0]});
        chk("a_upd", {31'd0, upd_a}, {31'd0, m_upd[0]});
        chk("a_stable", {31'd0, stb_a}, {31'd0, m_stb[0]});
        chk("a_tmo", {31'd0, tmo_a}, {31'd0, m_tmo[0]});
        chk("b_sync", {16'd0, sync_b}, {16'd0, m_sync[1]});
        chk("b_upd", {31'd0, upd_b}, {31'd0, m_upd[1]});
        chk("b_stable", {31'd0, stb_b}, {31'd0, m_stb[1]});
        chk("b_tmo", {31'd0, tmo_b}, {31'd0, m_tmo[1]});
`ifdef BUS_SYNC_STABLE_GLITCH_CNT_EN
        chk("a_glitch_cnt", {16'd0, gc_a}, m_gc[0]);
        chk("b_glitch_cnt", {16'd0, gc_b}, m_gc[1]);
`endif
    endtask

    // Called just after a falling edge: drive, let one rising edge pass, update model, check.
    task automatic do_cycle(input logic [7:0] ba, input logic [15:0] bb, input logic ca, input logic cb);
        in_a = ba; in_b = bb; clr_a = ca; clr_b = cb;
        @(posedge clk);
        if (rst_a) model_reset(0); else model_edge(0, {8'd0, ba}, ca);
        if (rst_b) model_reset(1); else model_edge(1, bb, cb);
        @(negedge clk);
        check_all();
    endtask

    int la, na, lb, nb, lt;
    logic [7:0]  ra;
    logic [15:0] rb;
    int ha, hb;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        in_a = 8'h00; in_b = 16'h0000;
        #1;
        model_reset(0); model_reset(1);
        check_all();
        chk("rst_sync_a", {24'd0, sync_a}, 32'h0000005A);
        chk("rst_flags_a", {29'd0, upd_a, stb_a, tmo_a}, 32'd0);
        @(negedge clk);
        do_cycle(8'h00, 16'h0000, 1'b0, 1'b0);
        do_cycle(8'h00, 16'h0000, 1'b0, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Post-reset latency towards 00 / 0000
        la = 0; na = 0; lb = 0; nb = 0;
        for (int i = 1; i <= 12; i++) begin
            do_cycle(8'h00, 16'h0000, 1'b0, 1'b0);
            if (upd_a) begin na++; if (la == 0) la = i; end
            if (upd_b) begin nb++; if (lb == 0) lb = i; end
        end
        chk("rst_lat_a", la, 32'd5);
        chk("rst_upd_pulses_a", na, 32'd1);
        chk("rst_lat_b", lb, 32'd7);
        chk("rst_upd_pulses_b", nb, 32'd1);

        // Step 00->A5 and 0000->BEEF
        la = 0; na = 0; lb = 0; nb = 0;
        for (int i = 1; i <= 12; i++) begin
            do_cycle(8'hA5, 16'hBEEF, 1'b0, 1'b0);
            if (upd_a) begin na++; if (la == 0) la = i; end
            if (upd_b) begin nb++; if (lb == 0) lb = i; end
        end
        chk("step_lat_a", la, 32'd5);
        chk("step_pulses_a", na, 32'd1);
        chk("step_sync_a", {24'd0, sync_a}, 32'h000000A5);
        chk("step_stable_a", {31'd0, stb_a}, 32'd1);
        chk("step_lat_b", lb, 32'd7);
        chk("step_sync_b", {16'd0, sync_b}, 32'h0000BEEF);

        // Glitch rejection 11 -> 22,22 -> 11
        for (int i = 0; i < 8; i++) do_cycle(8'h11, 16'hBEEF, 1'b0, 1'b0);
        na = 0;
        do_cycle(8'h22, 16'hBEEF, 1'b0, 1'b0);
        if (upd_a) na++;
        do_cycle(8'h22, 16'hBEEF, 1'b0, 1'b0);
        if (upd_a) na++;
        for (int i = 0; i < 8; i++) begin
            do_cycle(8'h11, 16'hBEEF, 1'b0, 1'b0);
            if (upd_a) na++;
        end
        chk("glitch_pulses_a", na, 32'd0);
        chk("glitch_sync_a", {24'd0, sync_a}, 32'h00000011);
`ifdef BUS_SYNC_STABLE_GLITCH_CNT_EN
        chk("glitch_cnt_a", {16'd0, gc_a}, 32'd1);
`endif

        // Timeout with toggling input
        for (int i = 0; i < 30; i++) do_cycle((i % 2) ? 8'h0F : 8'hF0, 16'hBEEF, 1'b0, 1'b0);
        chk("tmo_set_a", {31'd0, tmo_a}, 32'd1);
        do_cycle(8'h0F, 16'hBEEF, 1'b1, 1'b0);
        chk("tmo_clr_a", {31'd0, tmo_a}, 32'd0);
        lt = 0;
        for (int i = 1; i <= 20; i++) begin
            do_cycle((i % 2) ? 8'hF0 : 8'h0F, 16'hBEEF, 1'b0, 1'b0);
            if (tmo_a && (lt == 0)) lt = i;
        end
        chk("tmo_reset_lat_a", lt, 32'd16);

        // Clear on the same edge the timeout would set
        do_cycle(8'h0F, 16'hBEEF, 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) do_cycle((i % 2) ? 8'hF0 : 8'h0F, 16'hBEEF, 1'b0, 1'b0);
        do_cycle(8'hF0, 16'hBEEF, 1'b1, 1'b0);
        chk("tmo_clr_wins_a", {31'd0, tmo_a}, 32'd0);
        do_cycle(8'h0F, 16'hBEEF, 1'b0, 1'b0);
        chk("tmo_after_clr_a", {31'd0, tmo_a}, 32'd0);

        // b: reset in the middle of a transition, then a fresh latency
        for (int i = 0; i < 12; i++) do_cycle(8'h33, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(8'h33, 16'hBEEF, 1'b0, 1'b0);
        rst_b = 1'b1;
        #1;
        model_reset(1);
        check_all();
        chk("mid_rst_sync_b", {16'd0, sync_b}, 32'h00001234);
        @(negedge clk);
        do_cycle(8'h33, 16'hBEEF, 1'b0, 1'b0);
        rst_b = 1'b0;
        lb = 0;
        for (int i = 1; i <= 12; i++) begin
            do_cycle(8'h33, 16'hBEEF, 1'b0, 1'b0);
            if (upd_b && (lb == 0)) lb = i;
        end
        chk("mid_rst_lat_b", lb, 32'd7);

        // Randomised hold-based traffic with occasional clears and resets
        ra = 8'h00; rb = 16'h0000; ha = 0; hb = 0;
        for (int i = 0; i < 800; i++) begin
            if (ha == 0) begin ra = 8'($urandom_range(0, 3)) * 8'h41; ha = $urandom_range(1, 8); end
            if (hb == 0) begin rb = 16'($urandom_range(0, 3)) * 16'h1111; hb = $urandom_range(1, 9); end
            ha--; hb--;
            rst_a = ($urandom_range(0, 199) == 0);
            rst_b = ($urandom_range(0, 199) == 0);
            do_cycle(ra, rb, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        do_cycle(ra, rb, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_sync_stable_n.md
Name: bus_sync_stable_n

Overview:
Parametrised multi-bit CDC bus synchroniser with a stability filter. Bus_in is static-ish data from another clock domain. It passes through a SYNC_STAGES-deep flop chain in the dest_clk domain. Bus_sync is updated only after STABLE_CNT consecutive identical synchronised samples. Adds an update strobe, a stable flag, and a sticky instability timeout for status and interrupt logic.

Parameters:
- BUS_BW, 8, bus width in bits (>=1)
- SYNC_STAGES, 2, synchroniser flop depth (>=2)
- STABLE_CNT, 3, consecutive equal synchronised samples required before acceptance (>=2)
- TMO_CYC, 256, consecutive not-stable cycles before Bus_tmo sets; 0 disables the timeout (>=0, <2^16)
- RST_VAL, 0, BUS_BW-bit reset value for the sync chain, prev register and Bus_sync

Ports:
- dest_clk  input  1  destination clock; all flops on rising edge
- dest_rst  input  1  asynchronous, active-high reset
- Bus_in  input  BUS_BW  asynchronous source bus
- tmo_clr  input  1  synchronous clear of Bus_tmo and the timeout counter
- Bus_sync  output  BUS_BW  filtered, synchronised bus (registered)
- Bus_upd  output  1  one-cycle pulse on the edge where Bus_sync changes value
- Bus_stable  output  1  registered: the synchronised value met the stability criterion on the last edge
- Bus_tmo  output  1  sticky: stability not reached for TMO_CYC consecutive cycles

Behaviour:
- Reset (dest_rst=1, async):
  - chain, prev and Bus_sync load RST_VAL
  - run counter, timeout counter, Bus_upd, Bus_stable and Bus_tmo load 0
  - reset mid-transition discards all partial stability history
- Chain: s[0] <= Bus_in; s[k] <= s[k-1]; samp = s[SYNC_STAGES-1].
- prev <= samp every edge; eq = (samp == prev).
- Run counter, width clog2(STABLE_CNT):
  - run <= eq ? min(run+1, STABLE_CNT-1) : 0
  - saturates; never wraps
- stable_c = eq && (run >= STABLE_CNT-2).
- On each edge when stable_c=1: Bus_sync <= samp.
  - Bus_upd <= (samp != Bus_sync); otherwise Bus_upd <= 0.
  - Bus_stable <= stable_c.
- Latency:
  - Bus_in changes and is captured at edge 1; Bus_sync shows it at edge SYNC_STAGES+STABLE_CNT (5 with defaults).
  - Bus_upd is high for exactly that one cycle.
- Glitch rejection: any samp change before STABLE_CNT equal samples resets run. Bus_sync holds its last accepted value and Bus_upd stays 0.
- Same value re-stabilising (A->B glitch->A): Bus_sync is rewritten with an unchanged value, so Bus_upd stays 0.
- Timeout (TMO_CYC>0), 16-bit counter tc:
  - tmo_clr=1: tc <= 0, Bus_tmo <= 0. Clear has priority over set in the same cycle.
  - else if stable_c=1: tc <= 0.
  - else: tc <= sat(tc+1); when tc+1 == TMO_CYC, Bus_tmo <= 1.
  - Bus_tmo stays set until tmo_clr or reset.
- TMO_CYC=0: Bus_tmo is constant 0 and no counter logic is inferred.
- Parameter violations (SYNC_STAGES<2, STABLE_CNT<2) are flagged by an elaboration-time check and are not functional modes.

Optional Feature:
- Macro: BUS_SYNC_STABLE_GLITCH_CNT_EN.
- Defined:
  - adds output glitch_cnt [15:0], reset 0, saturating at 16'hFFFF
  - increments on every edge where samp != prev and prev != Bus_sync (a pending value discarded before acceptance)
  - cleared together with Bus_tmo by tmo_clr (clear wins)
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset with RST_VAL=8'h5A, Bus_in=8'h00 -> Bus_sync=8'h5A and Bus_upd/Bus_stable/Bus_tmo=0 during reset. After release, Bus_sync=8'h00 at edge 5 with a single Bus_upd pulse.
- Defaults, Bus_in steps 8'h00->8'hA5 held -> Bus_sync=8'hA5 exactly at the 5th dest_clk edge after capture; Bus_upd high one cycle; Bus_stable stays 1.
- Bus_in 8'h11, then 8'h22 for 2 cycles, then back to 8'h11 -> Bus_sync stays 8'h11; Bus_upd never pulses; glitch_cnt (macro on) = 1.
- Bus_in toggling every cycle with TMO_CYC=16 -> Bus_tmo sets on the 16th not-stable cycle and stays set. Pulse tmo_clr while toggling -> Bus_tmo=0, then re-sets 16 cycles later.
- tmo_clr asserted on the same edge the timeout would set -> Bus_tmo remains 0.
- SYNC_STAGES=3, STABLE_CNT=4, BUS_BW=16, step 16'h0000->16'hBEEF -> Bus_sync=16'hBEEF at edge 7. Assert dest_rst at edge 5 -> outputs return to RST_VAL and a fresh 7-edge latency applies after release.
